muldiv_seq: RTL and testbench

- Iterative multi-cycle sequencer for RV32M MUL/DIV/DIVU/REM/REMU ops.
- The ALU decoder assigns these ops the control codes 1010/1011/1100/1101/1110.
- Sits beside the single-cycle ALU in the execute stage. It accepts one op via a valid/ready handshake and runs a radix-2 shift-add/shift-subtract loop. It returns a registered result with a one-cycle done pulse; the pipeline stalls on busy.

---
 rtl/muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_muldiv_seq.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative radix-2 sequencer for RV32M MUL/DIV/DIVU/REM/REMU.
// Accepts one op through a valid/ready handshake, runs XLEN shift-add or
// shift-subtract iterations and then a sign fix-up. It returns a registered
// result with a one-cycle done pulse. Divide-by-zero and signed overflow skip
// the loop and are answered one cycle after acceptance.
module muldiv_seq #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [3:0]      alu_ctrl,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int CW = $clog2(XLEN + 1);

  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  state_t          state;
  logic [CW-1:0]   counter;
  logic [3:0]      op;        // latched op code
  logic [XLEN-1:0] hi;        // MUL: upper product / DIV: partial remainder
  logic [XLEN-1:0] lo;        // MUL: multiplier, then low product / DIV: dividend, then quotient
  logic [XLEN-1:0] m;         // MUL: multiplicand / DIV: divisor magnitude
  logic            neg;       // negate the selected result in FIXUP

  logic            is_op, accept, signed_op, is_div_q, a_neg, b_neg;
  logic            div_zero, overflow, special;
  logic [XLEN-1:0] abs_a, abs_b, special_res, fix_val, fix_res;
  logic [XLEN:0]   mul_sum, div_shift, div_diff;

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  // Decode the request and the special cases that bypass the loop.
  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    is_op       = (alu_ctrl >= OP_MUL) && (alu_ctrl <= OP_REMU);
    accept      = in_valid && is_op && !flush;
    signed_op   = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_REM);
    is_div_q    = (alu_ctrl == OP_DIV) || (alu_ctrl == OP_DIVU);
    a_neg       = signed_op && op_a[XLEN-1];
    b_neg       = signed_op && op_b[XLEN-1];
    abs_a       = a_neg ? -op_a : op_a;
    abs_b       = b_neg ? -op_b : op_b;
    div_zero    = (alu_ctrl != OP_MUL) && (op_b == '0);
    overflow    = signed_op && (op_a == {1'b1, {(XLEN-1){1'b0}}}) && (op_b == '1);
    special     = div_zero || overflow;
    special_res = '0;
    if (div_zero)
      special_res = is_div_q ? '1 : op_a;
    else if (overflow)
      special_res = is_div_q ? op_a : '0;
  end

  // One iteration step for each algorithm, plus the fix-up selection.
  always_comb begin
    mul_sum   = {1'b0, hi} + (lo[0] ? {1'b0, m} : '0);
    div_shift = {hi, lo[XLEN-1]};
    div_diff  = div_shift - {1'b0, m};
    fix_val   = ((op == OP_REM) || (op == OP_REMU)) ? hi : lo;
    fix_res   = neg ? -fix_val : fix_val;
  end

  // Sequencer FSM with registered done/result.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      counter <= '0;
      op      <= '0;
      hi      <= '0;
      lo      <= '0;
      m       <= '0;
      neg     <= 1'b0;
      done    <= 1'b0;
      result  <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            op <= alu_ctrl;
            if (special) begin
              result <= special_res;
              done   <= 1'b1;
              state  <= DONE;
            end else begin
              counter <= CW'(XLEN);
              hi      <= '0;
              if (alu_ctrl == OP_MUL) begin
                lo  <= op_b;
                m   <= op_a;
                neg <= 1'b0;
              end else begin
                lo  <= abs_a;
                m   <= abs_b;
                neg <= (alu_ctrl == OP_DIV) ? (a_neg ^ b_neg) : a_neg;
              end
              state <= CALC;
            end
          end
        end
        CALC: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            if (op == OP_MUL) begin
              hi <= mul_sum[XLEN:1];
              lo <= {mul_sum[0], lo[XLEN-1:1]};
            end else if (!div_diff[XLEN]) begin
              hi <= div_diff[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b1};
            end else begin
              hi <= div_shift[XLEN-1:0];
              lo <= {lo[XLEN-2:0], 1'b0};
            end
            counter <= counter - CW'(1);
            if (counter == CW'(1))
              state <= FIXUP;
          end
        end
        FIXUP: begin
          if (flush) begin
            state <= IDLE;
          end else begin
            result <= fix_res;
            done   <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed self-checking bench for muldiv_seq (XLEN=32).
module tb_muldiv_seq;

  localparam logic [3:0] OP_MUL  = 4'b1010;
  localparam logic [3:0] OP_DIV  = 4'b1011;
  localparam logic [3:0] OP_DIVU = 4'b1100;
  localparam logic [3:0] OP_REM  = 4'b1101;
  localparam logic [3:0] OP_REMU = 4'b1110;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  alu_ctrl = 4'b0000;
  logic [31:0] op_a = '0;
  logic [31:0] op_b = '0;
  logic        flush = 1'b0;
  logic        busy;
  logic        done;
  logic [31:0] result;

  int total = 0;
  int bad   = 0;
  logic [31:0] last_res = '0;

  muldiv_seq #(.XLEN(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .alu_ctrl (alu_ctrl),
    .op_a     (op_a),
    .op_b     (op_b),
    .flush    (flush),
    .busy     (busy),
    .done     (done),
    .result   (result)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    total++;
    if ({in_ready, busy, done} !== 3'b100 || result !== 32'h0) begin
      bad++;
      $display("FAIL reset: ready/busy/done=%b result=%h, want 100 / 00000000",
               {in_ready, busy, done}, result);
    end
  endtask

  // Issue one op, measure latency (edges from acceptance to done, acceptance
  // edge counted as 1) and busy cycles, then check the result and its hold.
  task automatic run_op(input string name, input logic [3:0] ctrl,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp, input int exp_lat, input bit hold);
    int n;
    int busy_n;
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      @(posedge clk); #1; w++;
    end
    total++;
    if (!in_ready) begin
      bad++;
      $display("FAIL %s ready_timeout: in_ready=%b, want 1", name, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = ctrl; op_a = a; op_b = b;
    @(posedge clk); #1;
    if (hold) begin
      alu_ctrl = OP_MUL; op_a = 32'd3; op_b = 32'd3;
    end else begin
      in_valid = 1'b0; op_a = 32'hDEAD_BEEF; op_b = 32'h1234_5678;
    end
    n = 1;
    busy_n = busy ? 1 : 0;
    while (!done && n < 60) begin
      @(posedge clk); #1;
      n++;
      if (busy) busy_n++;
    end
    in_valid = 1'b0;
    total++;
    if (n !== exp_lat || !done) begin
      bad++;
      $display("FAIL %s latency: got %0d done=%b, want %0d", name, n, done, exp_lat);
    end
    total++;
    if (busy_n !== exp_lat) begin
      bad++;
      $display("FAIL %s busy_cycles: got %0d, want %0d", name, busy_n, exp_lat);
    end
    total++;
    if (result !== exp) begin
      bad++;
      $display("FAIL %s result: got %h, want %h", name, result, exp);
    end
    @(posedge clk); #1;
    total++;
    if (done !== 1'b0 || in_ready !== 1'b1 || result !== exp) begin
      bad++;
      $display("FAIL %s after_done: done=%b in_ready=%b result=%h, want 0 1 %h",
               name, done, in_ready, result, exp);
    end
    last_res = exp;
  endtask

  task automatic test_mul();
    run_op("mul_7x6",   OP_MUL, 32'd7,        32'd6,        32'd42,       34, 1'b0);
    run_op("mul_m1xm1", OP_MUL, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 34, 1'b0);
  endtask

  task automatic test_div();
    run_op("div_m7_2",  OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_m7_2",  OP_REM,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 34, 1'b0);
    run_op("div_7_m2",  OP_DIV,  32'd7,        32'hFFFFFFFE, 32'hFFFFFFFD, 34, 1'b0);
    run_op("rem_7_m2",  OP_REM,  32'd7,        32'hFFFFFFFE, 32'd1,        34, 1'b0);
    run_op("divu_100_7", OP_DIVU, 32'd100,     32'd7,        32'd14,       34, 1'b0);
    run_op("remu_100_7", OP_REMU, 32'd100,     32'd7,        32'd2,        34, 1'b0);
  endtask

  task automatic test_special();
    run_op("divu_by0", OP_DIVU, 32'd5,        32'd0,        32'hFFFFFFFF, 1, 1'b0);
    run_op("rem_by0",  OP_REM,  32'd5,        32'd0,        32'd5,        1, 1'b0);
    run_op("div_ovf",  OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    run_op("rem_ovf",  OP_REM,  32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0);
  endtask

  task automatic test_flush();
    bit saw_done;
    saw_done = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = OP_DIV; op_a = 32'd1000; op_b = 32'd3;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) begin
      @(posedge clk); #1;
      if (done) saw_done = 1'b1;
    end
    @(negedge clk);
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    if (done) saw_done = 1'b1;
    total++;
    if (busy !== 1'b0 || saw_done || result !== last_res) begin
      bad++;
      $display("FAIL flush: busy=%b saw_done=%b result=%h, want 0 0 %h",
               busy, saw_done, result, last_res);
    end
    // flush while idle blocks acceptance
    @(negedge clk);
    in_valid = 1'b1; flush = 1'b1; alu_ctrl = OP_MUL; op_a = 32'd2; op_b = 32'd2;
    @(posedge clk); #1;
    in_valid = 1'b0; flush = 1'b0;
    total++;
    if (busy !== 1'b0 || in_ready !== 1'b1) begin
      bad++;
      $display("FAIL flush_idle: busy=%b in_ready=%b, want 0 1", busy, in_ready);
    end
    run_op("mul_after_flush", OP_MUL, 32'd3, 32'd5, 32'd15, 34, 1'b0);
  endtask

  task automatic test_handshake();
    bit moved;
    moved = 1'b0;
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = 4'b0010; op_a = 32'd9; op_b = 32'd9;
    repeat (6) begin
      @(posedge clk); #1;
      if (busy || done || !in_ready) moved = 1'b1;
    end
    in_valid = 1'b0;
    total++;
    if (moved || result !== last_res) begin
      bad++;
      $display("FAIL bad_ctrl: reacted=%b result=%h, want 0 %h", moved, result, last_res);
    end
    // in_valid held with a different op during busy must be ignored
    run_op("divu_hold", OP_DIVU, 32'd100, 32'd7, 32'd14, 34, 1'b1);
  endtask

  task automatic test_async_reset();
    @(negedge clk);
    in_valid = 1'b1; alu_ctrl = OP_MUL; op_a = 32'd7; op_b = 32'd6;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    total++;
    if ({in_ready, busy, done} !== 3'b100 || result !== 32'h0) begin
      bad++;
      $display("FAIL async_reset: ready/busy/done=%b result=%h, want 100 / 00000000",
               {in_ready, busy, done}, result);
    end
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      bad++;
      $display("FAIL reset_release: busy=%b done=%b, want 0 0", busy, done);
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_mul();
    test_div();
    test_special();
    test_flush();
    test_handshake();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
